// File: rtl/pwm_multi.sv
// Multi-channel PWM generator sharing one prescaled time base.
// Edge- or center-aligned counting. Period, duty and mode are double-buffered:
// a load fills staging, and the next period boundary copies staging into the
// active set, so a period is never cut short or stretched mid-way.

// Per-channel output stage: registered compare against the shared count.
module pwm_multi_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty,
  input  logic             inv,
  output logic             pwm
);

  // Output sits at the idle level (inv) until the time base has ticked once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pwm <= 1'b0;
    else if (!run) pwm <= inv;
    else           pwm <= (count < duty) ^ inv;
  end

endmodule

module pwm_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int PRESC_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [PRESC_W-1:0]        prescale,
  input  logic [WIDTH-1:0]          period,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic                      load,
  input  logic                      center_mode,
  input  logic [CHANNELS-1:0]       invert,
  output logic [CHANNELS-1:0]       pwm_out,
  output logic                      period_tick
);

  typedef struct packed {
    logic                             center;
    logic [WIDTH-1:0]                 period;
    logic [CHANNELS-1:0][WIDTH-1:0]   duty;
  } cfg_t;

  cfg_t               stage, act;
  logic               pending;

  logic [PRESC_W-1:0] pcount;
  logic               tick;

  logic [WIDTH-1:0]   count, cnt_nxt;
  logic               dir_down, dir_nxt;
  logic               running;
  logic               boundary;
  logic [1:0]         bnd_pipe;

  // The >= compare lets a live decrease of prescale take effect immediately
  // instead of waiting for pcount to wrap.
  assign tick = en && (pcount >= prescale);

  // Prescaler: free-runs while enabled, restarts after each tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               pcount <= '0;
    else if (!en || tick)  pcount <= '0;
    else                   pcount <= pcount + 1'b1;
  end

  // Next count/direction. Increments only happen below the active period,
  // so nothing wraps even with period at its maximum value.
  always_comb begin
    cnt_nxt = count;
    dir_nxt = dir_down;
    if (!running) begin
      // First tick after enable restarts the period at count 0.
      cnt_nxt = '0;
    end else if (!act.center) begin
      cnt_nxt = (count >= act.period) ? '0 : count + 1'b1;
    end else if (!dir_down && (count < act.period)) begin
      cnt_nxt = count + 1'b1;
    end else if (count != '0) begin
      cnt_nxt = count - 1'b1;
      dir_nxt = 1'b1;
    end else begin
      // Center mode with period 0: count is pinned at 0.
      cnt_nxt = '0;
    end
    if (cnt_nxt == '0) dir_nxt = 1'b0;
  end

  // Every tick that lands the count on 0 starts a new period.
  assign boundary = tick && (cnt_nxt == '0);

  // Main counter, direction and the running flag; all cleared while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      dir_down <= 1'b0;
      running  <= 1'b0;
    end else if (!en) begin
      count    <= '0;
      dir_down <= 1'b0;
      running  <= 1'b0;
    end else if (tick) begin
      count    <= cnt_nxt;
      dir_down <= dir_nxt;
      running  <= 1'b1;
    end
  end

  // Staging capture. A load coincident with a boundary keeps pending set so
  // the freshly staged values go out on the following boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage   <= '0;
      pending <= 1'b0;
    end else begin
      if (load) begin
        stage.center <= center_mode;
        stage.period <= period;
        stage.duty   <= duty;
      end
      pending <= load | (pending & ~boundary);
    end
  end

  // Active set only changes on a boundary, so outputs stay glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       act <= '0;
    else if (boundary && pending)  act <= stage;
  end

  // Boundary marker delayed to line up with the registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      bnd_pipe <= '0;
    else if (!en) bnd_pipe <= '0;
    else          bnd_pipe <= {bnd_pipe[0], boundary};
  end

  assign period_tick = bnd_pipe[1];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_multi_ch #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .run   (en && running),
      .count (count),
      .duty  (act.duty[g]),
      .inv   (invert[g]),
      .pwm   (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: expected output waveforms are derived from
// closed-form period/duty arithmetic and queued when a run is launched; a
// negedge monitor pops and compares one entry per clock.
module tb_pwm_multi;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int PW = 8;

  typedef logic [CH-1:0][W-1:0] dv_t;
  typedef struct packed { logic [CH-1:0] pwm; logic tick; } exp_t;

  logic          clk = 1'b0;
  logic          rst, en, load, center_mode;
  logic [PW-1:0] prescale;
  logic [W-1:0]  period;
  dv_t           duty;
  logic [CH-1:0] invert, pwm_out;
  logic          period_tick;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .prescale    (prescale),
    .period      (period),
    .duty        (duty),
    .load        (load),
    .center_mode (center_mode),
    .invert      (invert),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_pass = 0;
  string       scen   = "reset";
  logic [31:0] mask;
  int          k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Expected outputs at queue entry i of a run. Entry 0 is sampled on the
  // negedge before en is first seen, so the edge that produced the count the
  // outputs show is j = i-2; ticks land on edges q, 2q+1, ...
  function automatic exp_t model(int i, int q, int p, bit cm, dv_t d0, dv_t d1, dv_t d2,
                                 int s1, int s2, logic [CH-1:0] inv);
    exp_t e;
    int   j, m, plen, ph, cnt, pidx;
    dv_t  d;
    j      = i - 2;
    e.pwm  = inv;
    e.tick = 1'b0;
    if (j < q) return e;
    m    = (j - q) / (q + 1);
    plen = cm ? ((p == 0) ? 1 : 2 * p) : p + 1;
    ph   = m % plen;
    cnt  = (ph > p) ? 2 * p - ph : ph;
    pidx = m / plen;
    d    = (pidx >= s2) ? d2 : (pidx >= s1) ? d1 : d0;
    for (int c = 0; c < CH; c++) e.pwm[c] = (cnt < int'(d[c])) ^ inv[c];
    e.tick = ((j - q) % (q + 1) == 0) && (ph == 0);
    return e;
  endfunction

  // One enabled run of n clocks with up to two in-flight loads (at loop
  // cycles l1/l2), whose duties become active from period index s1/s2.
  // Ends by dropping en and expecting the idle level.
  task automatic run(input string name, input int n, input int q, input int p, input bit cm,
                     input logic [CH-1:0] inv, input dv_t d0,
                     input int l1, input dv_t d1, input int s1,
                     input int l2, input dv_t d2, input int s2);
    scen        = name;
    prescale    = PW'(q);
    period      = W'(p);
    center_mode = cm;
    invert      = inv;
    duty        = d0;
    load        = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i <= n; i++) sb.push_back(model(i, q, p, cm, d0, d1, d2, s1, s2, inv));
    sb.push_back(exp_t'{pwm: inv, tick: 1'b0});
    sb.push_back(exp_t'{pwm: inv, tick: 1'b0});
    en = 1'b1;
    for (int c = 0; c < n; c++) begin
      load = (c == l1) || (c == l2);
      if (c == l1) duty = d1;
      if (c == l2) duty = d2;
      @(posedge clk); #1;
    end
    load = 1'b0;
    en   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: one scoreboard entry per clock, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk({scen, "/pwm"},  32'(pwm_out),     32'(mon_e.pwm));
      chk({scen, "/tick"}, 32'(period_tick), 32'(mon_e.tick));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; prescale = '0; period = '0;
    duty = '0; center_mode = 1'b0; invert = '0;
    @(posedge clk); #1;
    chk("reset/pwm",  32'(pwm_out),     32'h0);
    chk("reset/tick", 32'(period_tick), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset while running with an output high.
    scen     = "rst_mid";
    prescale = 0; period = 9; center_mode = 0; invert = 4'b1000;
    duty     = {8'd0, 8'd0, 8'd10, 8'd3};
    load = 1'b1; @(posedge clk); #1; load = 1'b0;
    en = 1'b1;
    k  = 0;
    while (pwm_out[0] !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    chk("rst_mid/ch0_high", 32'(pwm_out[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid/pwm",  32'(pwm_out),     32'h0);
    chk("rst_mid/tick", 32'(period_tick), 32'h0);
    en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Edge mode P=9: duty 3, 100% at P+1, 0%, P.
    run("edge_p9", 25, 0, 9, 1'b0, 4'b0000, {8'd9, 8'd0, 8'd10, 8'd3},
        -1, '0, 1000, -1, '0, 1000);
    run("edge_inv", 25, 0, 9, 1'b0, 4'b0010, {8'd9, 8'd0, 8'd10, 8'd3},
        -1, '0, 1000, -1, '0, 1000);
    // Prescaled: period 20 clks, ch0 high 8 clks.
    run("presc3", 45, 3, 4, 1'b0, 4'b0000, {8'd0, 8'd5, 8'd4, 8'd2},
        -1, '0, 1000, -1, '0, 1000);
    // Center mode P=4: 0,1,2,3,4,3,2,1.
    run("center_p4", 30, 0, 4, 1'b1, 4'b0000, {8'd1, 8'd5, 8'd4, 8'd2},
        -1, '0, 1000, -1, '0, 1000);
    run("center_p0", 12, 1, 0, 1'b1, 4'b1000, {8'd0, 8'd1, 8'd0, 8'd1},
        -1, '0, 1000, -1, '0, 1000);
    // Mid-period load goes out next period; load on the boundary one later.
    run("shadow", 35, 0, 9, 1'b0, 4'b0000, {8'd0, 8'd5, 8'd1, 8'd2},
        5, {8'd10, 8'd5, 8'd1, 8'd7}, 1, 10, {8'd10, 8'd3, 8'd9, 8'd4}, 2);
    // Full-range period: no overflow in count or compare.
    run("max_edge", 520, 0, 255, 1'b0, 4'b0100, {8'd255, 8'd128, 8'd0, 8'd255},
        -1, '0, 1000, -1, '0, 1000);
    run("max_center", 520, 0, 255, 1'b1, 4'b0000, {8'd255, 8'd1, 8'd0, 8'd255},
        -1, '0, 1000, -1, '0, 1000);

    // Live prescale drop 3 -> 1 with pcount already past the new limit.
    // P=0 edge: every tick is a boundary; expected ticks at edges 3,7,10,12,14.
    scen     = "presc_live";
    prescale = 3; period = 0; center_mode = 0; invert = '0; duty = {4{8'd1}};
    load = 1'b1; @(posedge clk); #1; load = 1'b0;
    @(posedge clk); #1;
    mask = '0;
    en   = 1'b1;
    for (int c = 0; c < 16; c++) begin
      prescale = (c >= 10) ? 8'd1 : 8'd3;
      @(posedge clk); #1;
      mask[c] = period_tick;
    end
    chk("presc_live/ticks", mask, 32'h0000A910);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator. It is the successor to the team's single-channel 8-bit fixed-period PWM.
- Adds configurable counter width, channel count, clock prescaler, programmable period, edge- or center-aligned counting, per-channel polarity, and glitch-free shadowed duty/period updates.
- Drives motor, LED and servo outputs from one shared time base.

Parameters:
WIDTH, 8, bit width of period, duty and the main counter
CHANNELS, 4, number of independent PWM outputs sharing the time base
PRESC_W, 8, bit width of the prescaler value

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
en  in  1  run enable; 0 = counters held, outputs at idle level
prescale  in  PRESC_W  tick divider; one counter tick every prescale+1 clk cycles (live, not shadowed)
period  in  WIDTH  period value P (shadowed)
duty  in  CHANNELS*WIDTH  per-channel duty, channel i at bits [i*WIDTH +: WIDTH] (shadowed)
load  in  1  one-cycle strobe; captures period/duty into staging and sets pending
center_mode  in  1  0 = edge-aligned, 1 = center-aligned (shadowed with period)
invert  in  CHANNELS  per-channel polarity; 1 inverts output (live)
pwm_out  out  CHANNELS  registered PWM outputs
period_tick  out  1  one-clk pulse at start of every PWM period

Behaviour:
- Reset (async): prescaler count, main count, direction (up), staging regs, active regs, pending all cleared. pwm_out = 0, period_tick = 0.
- Prescaler:
  - Counts clk cycles while en=1.
  - Tick is asserted when pcount >= prescale, and pcount then returns to 0. The >= comparison handles a live decrease of prescale.
  - prescale = 0 gives a tick every clk.
- Main counter advances only on tick.
  - Edge mode: 0,1,..,P, then wrap to 0. Period = (P+1) ticks.
  - Center mode: up 0..P, then down P-1..1, then 0 again. Period = 2P ticks.
  - Center mode with P = 0: count stays 0; every tick is a period start.
- Period boundary:
  - Defined as the tick on which the count becomes 0 (wrap or down-count reaching 0).
  - The first tick after en rises also counts as a boundary.
- Shadowing:
  - load copies period, duty and center_mode into staging regs and sets pending.
  - At a boundary with pending=1, active regs take staging and pending clears, in the same cycle.
  - load coincident with a boundary: the boundary uses the old staging contents. The new values are staged and pending stays set.
  - Repeated loads before a boundary: the last one wins.
- Compare: raw_i = (count < duty_act_i), unsigned WIDTH-bit compare, evaluated on the count value in effect after the tick.
  - Edge mode: high for duty_act_i ticks per period; duty 0 gives 0%; duty >= P+1 gives 100%.
  - Center mode: high while count < duty_act_i, so the pulse is centered on the count-0 point. duty 0 gives 0%; duty > P gives 100%.
- Output: pwm_out[i] <= raw_i ^ invert[i], registered, one clk after the count update.
- period_tick: registered, high for exactly one clk, in the cycle pwm_out reflects count 0.
- en=0:
  - Prescaler, count and direction cleared synchronously. Active/staging regs retained; loads are still accepted.
  - pwm_out <= invert, i.e. the inactive level. period_tick = 0.
- en rising: first tick occurs after prescale+1 clks and applies pending.
- Arithmetic: all counters wrap-free by construction. P = 2^WIDTH-1 is legal, with no overflow in the compare.

Test Plan:
- Reset mid-run, with rst asserted while outputs are high → pwm_out = 0 and period_tick = 0 immediately; after release and en=1, operation restarts from count 0.
- WIDTH=8, prescale=0, edge mode, P=9, duty0=3, load then en=1 → pwm_out[0] high 3 clks, low 7 clks, period 10 clks; period_tick every 10 clks.
- Same setup, duty0=0 and duty1=10 → ch0 constant 0, ch1 constant 1; invert[1]=1 → ch1 constant 0.
- prescale=3, P=4, duty=2, edge mode → period 20 clks, high 8 clks; change prescale to 1 mid-count → next tick within 2 clks, no hang.
- Center mode, P=4, duty=2, prescale=0 → count 0,1,2,3,4,3,2,1; output high at counts 0,1 (1,1,0,0,0,0,0,1 pattern), period 8 clks, symmetric pulse.
- load duty=7 mid-period with old duty=2, P=9 → current period still high 2 ticks, next period high 7 ticks. load on the boundary cycle → applied one period later. en=0 mid-period → outputs go to invert level and count restarts at 0 on re-enable.
